// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundle between the writeback sources, issue stage, register file and wb_arbiter.
// Latency: none, this is a signal bundle only.
// Backpressure: sources stall on alu_ready/lsu_ready; the register-file write side never stalls.
//
// Port summary
//   alu_valid/alu_rd/alu_data -> alu_ready   ALU writeback request and its accept
//   lsu_valid/lsu_rd/lsu_data -> lsu_ready   LSU writeback request and its accept
//   rsv_valid/rsv_rd                         issue stage destination reservation
//   flush                                    clears the busy scoreboard
//   rs1/rs2 -> rs1_busy/rs2_busy             combinational RAW hazard query
//   wb_we/wb_a2/wb_din                       register-file write port (reg_wr/a2/din)
// Modports: master = sources, issue stage and register file; slave = wb_arbiter.
interface wb_arbiter_if #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5
);

  // ALU writeback source
  logic                alu_valid;
  logic [REG_BITS-1:0] alu_rd;
  logic [XLEN-1:0]     alu_data;
  logic                alu_ready;

  // LSU writeback source
  logic                lsu_valid;
  logic [REG_BITS-1:0] lsu_rd;
  logic [XLEN-1:0]     lsu_data;
  logic                lsu_ready;

  // Issue stage reservation and hazard query
  logic                rsv_valid;
  logic [REG_BITS-1:0] rsv_rd;
  logic                flush;
  logic [REG_BITS-1:0] rs1;
  logic [REG_BITS-1:0] rs2;
  logic                rs1_busy;
  logic                rs2_busy;

  // Register file write port
  logic                wb_we;
  logic [REG_BITS-1:0] wb_a2;
  logic [XLEN-1:0]     wb_din;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output rsv_valid, rsv_rd, flush, rs1, rs2,
    input  rs1_busy, rs2_busy,
    input  wb_we, wb_a2, wb_din
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  rsv_valid, rsv_rd, flush, rs1, rs2,
    output rs1_busy, rs2_busy,
    output wb_we, wb_a2, wb_din
  );

endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin share of the register-file write port between ALU and LSU, plus busy scoreboard.
// Latency: grant in cycle N -> wb_we/wb_a2/wb_din in cycle N+1; busy clears on the edge ending N+1.
// Backpressure: the losing source stalls on its own ready; the output stage never stalls, no internal queue.
//
// Port summary
//   clk    rising-edge clock
//   rst    asynchronous active-low reset; holds both readys low while asserted
//   bus    wb_arbiter_if.slave: writeback requests, reservation, flush, rs1/rs2 query, write port
module wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5,
  parameter int NUM_REGS = 32
) (
  input  logic           clk,
  input  logic           rst,
  wb_arbiter_if.slave    bus
);

  // Which source was granted most recently; the other one wins the next tie.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  // Registered write toward the register file.
  typedef struct packed {
    logic                we;
    logic [REG_BITS-1:0] a2;
    logic [XLEN-1:0]     din;
  } wb_stage_t;

  src_e                rr_q,    rr_d;
  wb_stage_t           stage_q, stage_d;
  logic [NUM_REGS-1:0] busy_q,  busy_d;

  logic alu_gnt;
  logic lsu_gnt;

  // ---------------------------------------------------------------------------
  // Arbitration. Grants are suppressed during flush so that nothing new enters
  // the output stage while the scoreboard is being wiped.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (!bus.flush) begin
      if (bus.alu_valid && bus.lsu_valid) begin
        if (rr_q == SRC_LSU) begin
          alu_gnt = 1'b1;
        end else begin
          lsu_gnt = 1'b1;
        end
      end else begin
        alu_gnt = bus.alu_valid;
        lsu_gnt = bus.lsu_valid;
      end
    end
  end

  // The flops are already held by the async reset; only the visible readys
  // need gating so no source believes it was accepted while in reset.
  assign bus.alu_ready = alu_gnt & rst;
  assign bus.lsu_ready = lsu_gnt & rst;

  // ---------------------------------------------------------------------------
  // Pointer and output stage next state.
  // A granted x0 write is consumed but leaves wb_we low and the address/data
  // registers untouched, so wb_a2/wb_din keep showing the last real write.
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_d     = rr_q;
    stage_d  = stage_q;
    stage_d.we = 1'b0;
    if (alu_gnt) begin
      rr_d = SRC_ALU;
      if (bus.alu_rd != '0) begin
        stage_d.we  = 1'b1;
        stage_d.a2  = bus.alu_rd;
        stage_d.din = bus.alu_data;
      end
    end else if (lsu_gnt) begin
      rr_d = SRC_LSU;
      if (bus.lsu_rd != '0) begin
        stage_d.we  = 1'b1;
        stage_d.a2  = bus.lsu_rd;
        stage_d.din = bus.lsu_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard. Order matters: release first so a same-cycle reservation
  // of the same register wins, then flush overrides everything.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (stage_q.we) begin
      busy_d[stage_q.a2] = 1'b0;
    end
    if (bus.rsv_valid && (bus.rsv_rd != '0)) begin
      busy_d[bus.rsv_rd] = 1'b1;
    end
    if (bus.flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q    <= SRC_LSU;
      stage_q <= '0;
      busy_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      stage_q <= stage_d;
      busy_q  <= busy_d;
    end
  end

  // Bit 0 is never set, so x0 queries read as not busy without extra logic.
  assign bus.rs1_busy = busy_q[bus.rs1];
  assign bus.rs2_busy = busy_q[bus.rs2];

  assign bus.wb_we  = stage_q.we;
  assign bus.wb_a2  = stage_q.a2;
  assign bus.wb_din = stage_q.din;

  // Structural sanity: one grant per cycle, and the write port never targets x0.
  a_one_grant : assert property (@(posedge clk) disable iff (!rst) !(alu_gnt && lsu_gnt));
  a_no_x0_wr  : assert property (@(posedge clk) disable iff (!rst) stage_q.we |-> (stage_q.a2 != '0));

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
// Latency: model expects write one cycle after grant, busy release one edge later.
// Backpressure: sources hold their request until the model says it was granted.
module tb_wb_arbiter;

  localparam int XLEN     = 32;
  localparam int REG_BITS = 5;
  localparam int NUM_REGS = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  wb_arbiter_if #(.XLEN(XLEN), .REG_BITS(REG_BITS)) bus();

  wb_arbiter #(
    .XLEN     (XLEN),
    .REG_BITS (REG_BITS),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: busy set, last granted source, pending register-file write.
  bit          m_busy[NUM_REGS];
  bit          m_last_lsu;
  bit          m_we;
  logic [4:0]  m_a2;
  logic [31:0] m_din;
  bit          g_alu;
  bit          g_lsu;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_last_lsu = 1'b1;
    m_we       = 1'b0;
    m_a2       = '0;
    m_din      = '0;
    g_alu      = 1'b0;
    g_lsu      = 1'b0;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.rsv_valid = 1'b0; bus.rsv_rd = '0;
    bus.flush     = 1'b0;
    bus.rs1       = '0;   bus.rs2    = '0;
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model,
  // then return 1ns after the rising edge ready for new stimulus.
  task automatic step();
    @(negedge clk);
    g_alu = 1'b0;
    g_lsu = 1'b0;
    if (!bus.flush) begin
      if (bus.alu_valid && bus.lsu_valid) begin
        if (m_last_lsu) g_alu = 1'b1;
        else            g_lsu = 1'b1;
      end else begin
        g_alu = bus.alu_valid;
        g_lsu = bus.lsu_valid;
      end
    end
    chk("alu_ready", 32'(bus.alu_ready), 32'(g_alu));
    chk("lsu_ready", 32'(bus.lsu_ready), 32'(g_lsu));
    chk("rs1_busy",  32'(bus.rs1_busy),  32'(m_busy[bus.rs1]));
    chk("rs2_busy",  32'(bus.rs2_busy),  32'(m_busy[bus.rs2]));
    chk("wb_we",     32'(bus.wb_we),     32'(m_we));
    if (m_we) begin
      chk("wb_a2",  32'(bus.wb_a2), 32'(m_a2));
      chk("wb_din", bus.wb_din,     m_din);
    end
    if (m_we) m_busy[m_a2] = 1'b0;
    if (bus.rsv_valid && bus.rsv_rd != 0) m_busy[bus.rsv_rd] = 1'b1;
    if (bus.flush) foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_we = 1'b0;
    if (g_alu) begin
      m_last_lsu = 1'b0;
      if (bus.alu_rd != 0) begin m_we = 1'b1; m_a2 = bus.alu_rd; m_din = bus.alu_data; end
    end else if (g_lsu) begin
      m_last_lsu = 1'b1;
      if (bus.lsu_rd != 0) begin m_we = 1'b1; m_a2 = bus.lsu_rd; m_din = bus.lsu_data; end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with requests present so the ready gating is visible.
    bus.alu_valid = 1'b1; bus.lsu_valid = 1'b1;
    #1;
    chk("rst_we",  32'(bus.wb_we),     0);
    chk("rst_a2",  32'(bus.wb_a2),     0);
    chk("rst_din", bus.wb_din,         0);
    chk("rst_ardy", 32'(bus.alu_ready), 0);
    chk("rst_lrdy", 32'(bus.lsu_ready), 0);
    idle();
    rst = 1'b1;

    // T1: async reset while a write sits in the output stage.
    bus.rsv_valid = 1'b1; bus.rsv_rd = 5'd9;
    step();
    bus.rsv_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hA5A5_0001;
    step();
    bus.alu_rd = 5'd6; bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h1234;
    chk("t1_we_before", 32'(bus.wb_we), 1);
    rst = 1'b0;
    #1;
    chk("t1_we",   32'(bus.wb_we),     0);
    chk("t1_a2",   32'(bus.wb_a2),     0);
    chk("t1_din",  bus.wb_din,         0);
    chk("t1_ardy", 32'(bus.alu_ready), 0);
    chk("t1_lrdy", 32'(bus.lsu_ready), 0);
    for (int r = 0; r < NUM_REGS; r++) begin
      bus.rs1 = 5'(r);
      #1;
      chk("t1_rs1_busy", 32'(bus.rs1_busy), 0);
    end
    idle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();

    // T3: simultaneous requests, ALU wins first after reset.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h11;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h22;
    #1;
    chk("t3_ardy_c0", 32'(bus.alu_ready), 1);
    chk("t3_lrdy_c0", 32'(bus.lsu_ready), 0);
    step();
    bus.alu_valid = 1'b0;
    #1;
    chk("t3_lrdy_c1", 32'(bus.lsu_ready), 1);
    chk("t3_a2_c1",   32'(bus.wb_a2),     3);
    step();
    bus.lsu_valid = 1'b0;
    #1;
    chk("t3_a2_c2", 32'(bus.wb_a2), 4);
    step();

    // T2: reserve, write, release.
    bus.rsv_valid = 1'b1; bus.rsv_rd = 5'd5; bus.rs1 = 5'd5;
    step();
    bus.rsv_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1;
    chk("t2_busy_c1", 32'(bus.rs1_busy),  1);
    chk("t2_ardy_c1", 32'(bus.alu_ready), 1);
    step();
    bus.alu_valid = 1'b0;
    #1;
    chk("t2_we_c2",   32'(bus.wb_we),    1);
    chk("t2_a2_c2",   32'(bus.wb_a2),    5);
    chk("t2_din_c2",  bus.wb_din,        32'hDEADBEEF);
    chk("t2_busy_c2", 32'(bus.rs1_busy), 1);
    step();
    #1;
    chk("t2_busy_c3", 32'(bus.rs1_busy), 0);
    step();

    // T4: x0 write is consumed but never reaches the register file.
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hFFFFFFFF;
    #1;
    chk("t4_lrdy", 32'(bus.lsu_ready), 1);
    step();
    bus.lsu_valid = 1'b0;
    #1;
    chk("t4_we", 32'(bus.wb_we), 0);
    step();

    // T5: flush while a write is in the output stage.
    bus.rsv_valid = 1'b1; bus.rsv_rd = 5'd7;
    step();
    bus.rsv_rd = 5'd9;
    step();
    bus.rsv_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
    step();
    bus.flush = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    #1;
    chk("t5_ardy_flush", 32'(bus.alu_ready), 0);
    chk("t5_we_flush",   32'(bus.wb_we),     1);
    chk("t5_a2_flush",   32'(bus.wb_a2),     7);
    step();
    bus.flush = 1'b0; bus.rs1 = 5'd7; bus.rs2 = 5'd9;
    #1;
    chk("t5_busy7", 32'(bus.rs1_busy), 0);
    chk("t5_busy9", 32'(bus.rs2_busy), 0);
    step();
    bus.alu_valid = 1'b0;
    step();

    // T6: release and reservation of the same register on one edge.
    bus.rsv_valid = 1'b1; bus.rsv_rd = 5'd12;
    step();
    bus.rsv_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'hC;
    step();
    bus.alu_valid = 1'b0;
    bus.rsv_valid = 1'b1; bus.rsv_rd = 5'd12; bus.rs1 = 5'd12;
    #1;
    chk("t6_we", 32'(bus.wb_we), 1);
    chk("t6_a2", 32'(bus.wb_a2), 12);
    step();
    bus.rsv_valid = 1'b0;
    #1;
    chk("t6_busy", 32'(bus.rs1_busy), 1);
    step();

    // Randomized traffic: sources hold requests until granted.
    idle();
    for (int c = 0; c < 1500; c++) begin
      if (g_alu || !bus.alu_valid) begin
        bus.alu_valid = ($urandom_range(0, 1) == 1);
        bus.alu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.alu_data  = $urandom;
      end
      if (g_lsu || !bus.lsu_valid) begin
        bus.lsu_valid = ($urandom_range(0, 1) == 1);
        bus.lsu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.lsu_data  = $urandom;
      end
      begin
        int r;
        r = $urandom_range(1, 31);
        bus.rsv_rd    = 5'(r);
        bus.rsv_valid = ($urandom_range(0, 2) == 0) && !m_busy[r];
      end
      bus.flush = ($urandom_range(0, 19) == 0);
      bus.rs1   = 5'($urandom_range(0, 31));
      bus.rs2   = 5'($urandom_range(0, 31));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
